// File: rtl/ewma_filter_mc_if.sv
// Sample/result bus of the multi-channel EWMA filter.
//
// Handshake: a sample transfers on a rising clk edge where in_valid and
// in_ready are both high; the source must hold in_ch/in_data/coef/mode
// stable while in_valid is high and must not wait on in_ready before raising
// in_valid. The result side has no backpressure: out_valid is a one-cycle
// pulse and out_ch/out_data hold until the next result. clear is a
// synchronous command that overrides any transfer in the same cycle.
interface ewma_filter_mc_if #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 8,
  parameter int CHANNELS = 2
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                     in_valid;
  logic                     in_ready;
  logic [CH_W-1:0]          in_ch;
  logic signed [DATA_W-1:0] in_data;
  logic [COEF_W-1:0]        coef;
  logic                     mode;
  logic                     clear;
  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic signed [DATA_W-1:0] out_data;

  // Sample source / result sink side.
  modport master (
    output in_valid, in_ch, in_data, coef, mode, clear,
    input  in_ready, out_valid, out_ch, out_data
  );

  // Filter side.
  modport slave (
    input  in_valid, in_ch, in_data, coef, mode, clear,
    output in_ready, out_valid, out_ch, out_data
  );
endinterface

// File: rtl/ewma_filter_mc.sv
// Multi-channel single-pole IIR (EWMA) filter: y += k*(x - y), k = coef/2^COEF_W.
// One serial LSB-first shift-add multiplier is shared by all channels; each
// sample takes COEF_W multiply cycles plus one update cycle. Output is either
// the smoothed value (low-pass) or the saturated residual x - y (high-pass).
module ewma_filter_mc #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 8,
  parameter int CHANNELS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ewma_filter_mc_if.slave         s_if,
  output logic [1:0]              o_state
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int P_W   = DATA_W + COEF_W + 1;
  localparam int CNT_W = $clog2(COEF_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COEF_W - 1);
  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_in_ready;
  logic   w_accept;

  // Per-channel filter state.
  logic signed [DATA_W-1:0] r_y [CHANNELS];

  // Operation latched at accept.
  logic signed [DATA_W-1:0] r_x;
  logic signed [DATA_W-1:0] r_yprev;
  logic [CH_W-1:0]          r_ch;
  logic                     r_mode;
  logic                     r_ch_ok;

  // Serial multiplier.
  logic signed [P_W-1:0]    r_mcand;
  logic [COEF_W-1:0]        r_mplier;
  logic signed [P_W-1:0]    r_acc;
  logic [CNT_W-1:0]         r_cnt;

  // Result registers.
  logic                     r_out_valid;
  logic [CH_W-1:0]          r_out_ch;
  logic signed [DATA_W-1:0] r_out_data;

  logic signed [DATA_W-1:0] w_y_sel;
  logic                     w_ch_ok;
  logic signed [DATA_W:0]   w_diff;
  logic signed [DATA_W-1:0] w_y_new;
  logic signed [DATA_W:0]   w_hp_wide;
  logic signed [DATA_W-1:0] w_hp_sat;

  assign s_if.in_ready  = w_in_ready;
  assign s_if.out_valid = r_out_valid;
  assign s_if.out_ch    = r_out_ch;
  assign s_if.out_data  = r_out_data;
  assign o_state        = r_state;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake; clear aborts everything and blocks accept.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_accept    = 1'b0;
    if (s_if.clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_in_ready = 1'b1;
          if (s_if.in_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = MULT;
          end
        end
        MULT:    if (r_cnt == CNT_LAST) w_state_nxt = UPDATE;
        UPDATE:  w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Select the addressed channel state; out-of-range channels read as zero.
  always_comb begin
    w_y_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (s_if.in_ch == CH_W'(c)) w_y_sel = r_y[c];
    end
  end

  assign w_ch_ok = (int'(s_if.in_ch) < CHANNELS);
  assign w_diff  = {s_if.in_data[DATA_W-1], s_if.in_data} - {w_y_sel[DATA_W-1], w_y_sel};

  // Floor shift of the product; the new value lies between y_prev and x so
  // the DATA_W-bit sum cannot overflow.
  assign w_y_new   = r_yprev + DATA_W'(r_acc >>> COEF_W);
  assign w_hp_wide = {r_x[DATA_W-1], r_x} - {w_y_new[DATA_W-1], w_y_new};

  // Saturate the high-pass residual to the signed DATA_W range.
  always_comb begin
    w_hp_sat = w_hp_wide[DATA_W-1:0];
    if (w_hp_wide[DATA_W] != w_hp_wide[DATA_W-1]) begin
      w_hp_sat = w_hp_wide[DATA_W] ? SAT_MIN : SAT_MAX;
    end
  end

  // Datapath: latch at accept, shift-add during MULT, write back and emit at UPDATE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) r_y[c] <= '0;
      r_x         <= '0;
      r_yprev     <= '0;
      r_ch        <= '0;
      r_mode      <= 1'b0;
      r_ch_ok     <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (s_if.clear) begin
        for (int c = 0; c < CHANNELS; c++) r_y[c] <= '0;
      end else begin
        if (w_accept) begin
          r_x      <= s_if.in_data;
          r_ch     <= s_if.in_ch;
          r_mode   <= s_if.mode;
          r_ch_ok  <= w_ch_ok;
          r_yprev  <= w_y_sel;
          r_mcand  <= {{COEF_W{w_diff[DATA_W]}}, w_diff};
          r_mplier <= s_if.coef;
          r_acc    <= '0;
          r_cnt    <= '0;
        end
        if (r_state == MULT) begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand <<< 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        if (r_state == UPDATE && r_ch_ok) begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (r_ch == CH_W'(c)) r_y[c] <= w_y_new;
          end
          r_out_valid <= 1'b1;
          r_out_ch    <= r_ch;
          r_out_data  <= r_mode ? w_hp_sat : w_y_new;
        end
      end
    end
  end
endmodule
